window_scanner: RTL and testbench
=================================

# window_scanner

Parametrised successor to the single-pixel image scanner. For each centre pixel of a runtime-sized image, in raster order, it walks a WIN×WIN neighbourhood and emits one (x, y) tap address per accepted advance. It handles image borders by replication (clamp) or by skipping edge centres. It feeds the line-buffer/pixel-fetch stage ahead of the median sorter.

## Interface
Parameters:
- ADDR_W, 8: width of each coordinate and size field.
- WIN, 3: window edge; odd, ≥3. R = (WIN-1)/2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE or DONE
- imgWidth  in  ADDR_W  image width in pixels; latched on accepted start
- imgHeight  in  ADDR_W  image height in pixels; latched on accepted start
- borderMode  in  1  0 = clamp/replicate, 1 = skip border centres; latched on start
- nextAddress  in  1  consumer accepts current tap; ignored unless addrValid
- xAddress  out  ADDR_W  tap column
- yAddress  out  ADDR_W  tap row
- centreX  out  ADDR_W  column of current centre pixel
- centreY  out  ADDR_W  row of current centre pixel
- tapIndex  out  clog2(WIN*WIN)  tap number in window, 0..WIN*WIN-1
- addrValid  out  1  tap outputs valid
- windowLast  out  1  current tap is the last of its window
- imageDone  out  1  level; high in DONE
- busy  out  1  high in SCAN

## Operation
- States:
  - IDLE: reset state.
  - SCAN: emitting taps.
  - DONE: holds imageDone until the next start or reset.
- Accepted start latches imgWidth, imgHeight and borderMode.
- Centre range:
  - Clamp mode: cx 0..W-1, cy 0..H-1.
  - Skip mode: cx R..W-1-R, cy R..H-1-R.
- Empty range goes straight to DONE with no taps. This covers W=0 or H=0 in either mode, and W<WIN or H<WIN in skip mode.
- Tap order within a window: dy = -R..+R (outer), dx = -R..+R (inner), row-major. tapIndex = (dy+R)*WIN + (dx+R).
- Coordinate arithmetic: computed in ADDR_W+2-bit signed, never wraps.
  - Clamp mode: x clamped to [0, W-1], y to [0, H-1].
  - Skip mode: no clamping is needed.
- Advance: addrValid && nextAddress moves to the next tap. windowLast advances the centre: cx++; at the row end cx resets and cy++.
- Last tap of last centre accepted → SCAN→DONE.
- start is ignored while in SCAN. nextAddress is ignored when addrValid=0.
- reset low, on any clock edge, forces IDLE. It overrides start and nextAddress in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered; no combinational path from any input to any output.
- Start with a non-empty range, accepted on edge n: from edge n, addrValid=1, busy=1, first tap (clamped (cx0-R, cy0-R)), tapIndex=0.
- Start with an empty range, accepted on edge n: from edge n, imageDone=1, addrValid=0.
- Handshake: a tap is accepted on an edge where addrValid && nextAddress. The next tap appears after that same edge.
  - One tap per cycle at full rate.
  - Outputs are held stable while nextAddress=0.
- Final tap accepted on edge k: after k, addrValid=0, busy=0, imageDone=1.
- Start in DONE: imageDone drops on the accepting edge and the scan restarts as from IDLE.
- Throughput: W·H·WIN² accepted taps per clamp-mode image.

## Structure
- Shared package scanner_pkg:
  - state encoding: IDLE, SCAN, DONE.
  - border-mode constants: BORDER_CLAMP=0, BORDER_SKIP=1.
- Sub-module window_tap_counter:
  - Holds the dx/dy offset counters.
  - Produces tapIndex and windowLast.
  - Has an advance input.
- Top level holds the centre counters, clamp logic, latched config and FSM.

## Test plan
- Clamp, W=4, H=3, WIN=3, nextAddress held 1:
  - First window taps are (0,0),(0,0),(1,0),(0,0),(0,0),(1,0),(0,1),(0,1),(1,1), with windowLast on tap 8.
  - imageDone rises after exactly 108 accepts.
- Skip, W=5, H=5:
  - First tap is (0,0) with centre (1,1); last tap is (4,4) with centre (3,3).
  - 81 taps total, then imageDone=1.
- Skip, W=2, H=2 (and clamp with W=0):
  - addrValid never rises; imageDone=1 from the start edge.
- Stall: nextAddress toggled 1/0 then held 0 for 10 cycles mid-window.
  - xAddress, yAddress and tapIndex stay constant while held.
  - Every accepted tap matches the reference model.
- Reset mid-scan: pull reset low for one cycle after 20 accepts.
  - All outputs are 0 on the next edge.
  - A following start restarts at tapIndex=0, centre (0,0).
- Edge width, clamp mode, W=255, H=1:
  - The centre-254 window shows x=254 for dx=+1 (clamped).
  - No coordinate wraps.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared definitions for the window scanner family: FSM encoding and border modes.
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scanState_e;

  localparam logic BORDER_CLAMP = 1'b0;
  localparam logic BORDER_SKIP  = 1'b1;

endpackage

// File: rtl/window_tap_counter.sv
// Row-major dx/dy offset walker for one WIN x WIN window; exposes next offsets so the
// parent can register tap addresses without an extra cycle.
module window_tap_counter #(
  parameter int unsigned WIN  = 3,
  parameter int unsigned TapW = $clog2(WIN * WIN),
  parameter int unsigned OffW = $clog2(WIN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            advance_i,
  output logic [OffW-1:0] dxNext_o,
  output logic [OffW-1:0] dyNext_o,
  output logic [TapW-1:0] tapIndex_o,
  output logic            windowLast_o
);

  logic [OffW-1:0] dxQ, dxD, dyQ, dyD;
  logic [TapW-1:0] tapQ, tapD;
  logic            lastQ;

  always_comb begin
    dxD  = dxQ;
    dyD  = dyQ;
    tapD = tapQ;
    if (clear_i) begin
      dxD  = '0;
      dyD  = '0;
      tapD = '0;
    end else if (advance_i) begin
      if (lastQ) begin
        dxD  = '0;
        dyD  = '0;
        tapD = '0;
      end else begin
        tapD = tapQ + TapW'(1);
        if (dxQ == OffW'(WIN - 1)) begin
          dxD = '0;
          dyD = dyQ + OffW'(1);
        end else begin
          dxD = dxQ + OffW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dxQ   <= '0;
      dyQ   <= '0;
      tapQ  <= '0;
      lastQ <= 1'b0;
    end else begin
      dxQ   <= dxD;
      dyQ   <= dyD;
      tapQ  <= tapD;
      lastQ <= (tapD == TapW'(WIN * WIN - 1));
    end
  end

  assign dxNext_o     = dxD;
  assign dyNext_o     = dyD;
  assign tapIndex_o   = tapQ;
  assign windowLast_o = lastQ;

endmodule

// File: rtl/window_scanner.sv
// Raster-order window scanner: walks every centre pixel and emits WIN x WIN tap
// addresses with clamp or skip border handling. All outputs are registered.
module window_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIN    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            imgWidth,
  input  logic [ADDR_W-1:0]            imgHeight,
  input  logic                         borderMode,
  input  logic                         nextAddress,
  output logic [ADDR_W-1:0]            xAddress,
  output logic [ADDR_W-1:0]            yAddress,
  output logic [ADDR_W-1:0]            centreX,
  output logic [ADDR_W-1:0]            centreY,
  output logic [$clog2(WIN*WIN)-1:0]   tapIndex,
  output logic                         addrValid,
  output logic                         windowLast,
  output logic                         imageDone,
  output logic                         busy
);

  localparam int unsigned R    = (WIN - 1) / 2;
  localparam int unsigned SW   = ADDR_W + 2;
  localparam int unsigned OffW = $clog2(WIN);

  typedef logic signed [SW-1:0] sCoord_t;
  localparam sCoord_t ROff = sCoord_t'(R);
  localparam sCoord_t One  = sCoord_t'(1);

  scanState_e        stateQ, stateD;
  logic [ADDR_W-1:0] cxQ, cxD, cyQ, cyD;
  logic [ADDR_W-1:0] widthQ, widthD, heightQ, heightD;
  logic              modeQ, modeD;
  logic              tapClear, tapAdvance, tapLast;
  logic [OffW-1:0]   dxNext, dyNext;

  logic [ADDR_W-1:0] startLo, scanLo, hiX, hiY;
  logic              startEmpty;
  sCoord_t           xRaw, yRaw, xMax, yMax;
  logic [ADDR_W-1:0] xC, yC;
  logic              inScanD;

  window_tap_counter #(
    .WIN (WIN),
    .TapW($clog2(WIN * WIN)),
    .OffW(OffW)
  ) uTapCounter (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clear_i     (tapClear),
    .advance_i   (tapAdvance),
    .dxNext_o    (dxNext),
    .dyNext_o    (dyNext),
    .tapIndex_o  (tapIndex),
    .windowLast_o(tapLast)
  );

  assign startLo = (borderMode == BORDER_SKIP) ? ADDR_W'(R) : '0;
  assign scanLo  = (modeQ == BORDER_SKIP) ? ADDR_W'(R) : '0;
  assign hiX     = widthQ - ADDR_W'(1) - scanLo;
  assign hiY     = heightQ - ADDR_W'(1) - scanLo;

  // Skip mode needs at least WIN pixels per axis to have any valid centre.
  assign startEmpty = (imgWidth == '0) || (imgHeight == '0) ||
                      ((borderMode == BORDER_SKIP) &&
                       ((imgWidth < ADDR_W'(WIN)) || (imgHeight < ADDR_W'(WIN))));

  always_comb begin
    stateD     = stateQ;
    cxD        = cxQ;
    cyD        = cyQ;
    widthD     = widthQ;
    heightD    = heightQ;
    modeD      = modeQ;
    tapClear   = 1'b0;
    tapAdvance = 1'b0;
    unique case (stateQ)
      IDLE, DONE: begin
        if (start) begin
          widthD   = imgWidth;
          heightD  = imgHeight;
          modeD    = borderMode;
          cxD      = startLo;
          cyD      = startLo;
          tapClear = 1'b1;
          stateD   = startEmpty ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (nextAddress) begin
          tapAdvance = 1'b1;
          if (tapLast) begin
            if (cxQ == hiX) begin
              cxD = scanLo;
              if (cyQ == hiY) stateD = DONE;
              else            cyD = cyQ + ADDR_W'(1);
            end else begin
              cxD = cxQ + ADDR_W'(1);
            end
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Tap coordinates for the next cycle, widened so edge offsets never wrap.
  always_comb begin
    xRaw = $signed({2'b00, cxD}) + $signed({{(SW - OffW){1'b0}}, dxNext}) - ROff;
    yRaw = $signed({2'b00, cyD}) + $signed({{(SW - OffW){1'b0}}, dyNext}) - ROff;
    xMax = $signed({2'b00, widthD}) - One;
    yMax = $signed({2'b00, heightD}) - One;
    if (xRaw[SW-1])       xC = '0;
    else if (xRaw > xMax) xC = xMax[ADDR_W-1:0];
    else                  xC = xRaw[ADDR_W-1:0];
    if (yRaw[SW-1])       yC = '0;
    else if (yRaw > yMax) yC = yMax[ADDR_W-1:0];
    else                  yC = yRaw[ADDR_W-1:0];
    inScanD = (stateD == SCAN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ     <= IDLE;
      cxQ        <= '0;
      cyQ        <= '0;
      widthQ     <= '0;
      heightQ    <= '0;
      modeQ      <= BORDER_CLAMP;
      xAddress   <= '0;
      yAddress   <= '0;
      centreX    <= '0;
      centreY    <= '0;
      addrValid  <= 1'b0;
      imageDone  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cxQ        <= cxD;
      cyQ        <= cyD;
      widthQ     <= widthD;
      heightQ    <= heightD;
      modeQ      <= modeD;
      xAddress   <= inScanD ? xC : '0;
      yAddress   <= inScanD ? yC : '0;
      centreX    <= inScanD ? cxD : '0;
      centreY    <= inScanD ? cyD : '0;
      addrValid  <= inScanD;
      imageDone  <= (stateD == DONE);
      busy       <= inScanD;
    end
  end

  assign windowLast = tapLast;

endmodule

// File: tb/tb_window_scanner.sv
// Self-checking bench for window_scanner against a loop-based tap-list model.
module tb_window_scanner;

  localparam int ADDR_W = 8;
  localparam int WIN    = 3;
  localparam int R      = (WIN - 1) / 2;
  localparam int TAPW   = $clog2(WIN * WIN);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] imgWidth, imgHeight;
  logic              borderMode;
  logic              nextAddress;
  logic [ADDR_W-1:0] xAddress, yAddress, centreX, centreY;
  logic [TAPW-1:0]   tapIndex;
  logic              addrValid, windowLast, imageDone, busy;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    int x;
    int y;
    int cx;
    int cy;
    int ti;
    int last;
  } tap_t;

  tap_t expQ[$];

  always #5 clk = ~clk;

  window_scanner #(
    .ADDR_W(ADDR_W),
    .WIN   (WIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imgWidth   (imgWidth),
    .imgHeight  (imgHeight),
    .borderMode (borderMode),
    .nextAddress(nextAddress),
    .xAddress   (xAddress),
    .yAddress   (yAddress),
    .centreX    (centreX),
    .centreY    (centreY),
    .tapIndex   (tapIndex),
    .addrValid  (addrValid),
    .windowLast (windowLast),
    .imageDone  (imageDone),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Every tap of the image, straight from the window/border rules.
  task automatic buildModel(input int w, input int h, input int mode);
    int lo, hiX, hiY;
    tap_t t;
    expQ.delete();
    if (w == 0 || h == 0) return;
    lo  = (mode == 1) ? R : 0;
    hiX = (mode == 1) ? w - 1 - R : w - 1;
    hiY = (mode == 1) ? h - 1 - R : h - 1;
    for (int cy = lo; cy <= hiY; cy++)
      for (int cx = lo; cx <= hiX; cx++)
        for (int dy = -R; dy <= R; dy++)
          for (int dx = -R; dx <= R; dx++) begin
            t.cx   = cx;
            t.cy   = cy;
            t.x    = (mode == 1) ? cx + dx : clampInt(cx + dx, 0, w - 1);
            t.y    = (mode == 1) ? cy + dy : clampInt(cy + dy, 0, h - 1);
            t.ti   = (dy + R) * WIN + (dx + R);
            t.last = (t.ti == WIN * WIN - 1) ? 1 : 0;
            expQ.push_back(t);
          end
  endtask

  // policy 0: always accept; 1: random accept plus ignored start noise; 2: toggle then stall.
  task automatic runScan(input int w, input int h, input int mode, input int policy,
                         input int abortAfter, output int accepts);
    int total, budget, cycles;
    logic na;
    buildModel(w, h, mode);
    total  = expQ.size();
    budget = total * 8 + 40;
    @(negedge clk);
    imgWidth    = ADDR_W'(w);
    imgHeight   = ADDR_W'(h);
    borderMode  = mode[0];
    start       = 1'b1;
    nextAddress = 1'($urandom_range(0, 1));
    @(negedge clk);
    start       = 1'b0;
    nextAddress = 1'b0;
    accepts = 0;
    cycles  = 0;
    while (expQ.size() > 0 && cycles < budget && !(abortAfter > 0 && accepts == abortAfter)) begin
      check("addrValid", addrValid, 1);
      check("busy", busy, 1);
      check("imageDoneLow", imageDone, 0);
      check("xAddress", xAddress, expQ[0].x);
      check("yAddress", yAddress, expQ[0].y);
      check("centreX", centreX, expQ[0].cx);
      check("centreY", centreY, expQ[0].cy);
      check("tapIndex", tapIndex, expQ[0].ti);
      check("windowLast", windowLast, expQ[0].last);
      case (policy)
        0:       na = 1'b1;
        1:       na = 1'($urandom_range(0, 1));
        default: na = (cycles < 4) ? ~cycles[0] : ((cycles < 14) ? 1'b0 : 1'b1);
      endcase
      nextAddress = na;
      if (policy == 1) begin
        start      = 1'($urandom_range(0, 1));
        imgWidth   = ADDR_W'($urandom);
        imgHeight  = ADDR_W'($urandom);
        borderMode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
      if (na) begin
        void'(expQ.pop_front());
        accepts++;
      end
    end
    start       = 1'b0;
    nextAddress = 1'b0;
    if (abortAfter > 0) begin
      check("abortAccepts", accepts, abortAfter);
      return;
    end
    check("tapsOutstanding", expQ.size(), 0);
    check("acceptCount", accepts, total);
    check("doneImageDone", imageDone, 1);
    check("doneAddrValid", addrValid, 0);
    check("doneBusy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idleAddrValid", addrValid, 0);
      check("idleImageDone", imageDone, 1);
    end
  endtask

  initial begin
    int acc;
    reset       = 1'b0;
    start       = 1'b0;
    imgWidth    = '0;
    imgHeight   = '0;
    borderMode  = 1'b0;
    nextAddress = 1'b0;
    repeat (2) @(negedge clk);
    check("rstX", xAddress, 0);
    check("rstY", yAddress, 0);
    check("rstTap", tapIndex, 0);
    check("rstValid", addrValid, 0);
    check("rstLast", windowLast, 0);
    check("rstDone", imageDone, 0);
    check("rstBusy", busy, 0);
    reset = 1'b1;

    // Clamp 4x3, full rate: 4*3*9 accepts.
    runScan(4, 3, 0, 0, 0, acc);
    check("clamp4x3Accepts", acc, 108);

    // Skip 5x5: 3x3 centres.
    runScan(5, 5, 1, 0, 0, acc);
    check("skip5x5Accepts", acc, 81);

    // Empty ranges.
    runScan(2, 2, 1, 0, 0, acc);
    check("skip2x2Accepts", acc, 0);
    runScan(0, 4, 0, 0, 0, acc);
    check("clampW0Accepts", acc, 0);

    // Stall mid-window.
    runScan(4, 3, 0, 2, 0, acc);

    // Random configurations and handshake.
    for (int i = 0; i < 6; i++)
      runScan($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 1), 1, 0, acc);

    // Reset mid-scan, with start and nextAddress asserted alongside.
    runScan(4, 3, 0, 0, 20, acc);
    reset       = 1'b0;
    start       = 1'b1;
    nextAddress = 1'b1;
    @(negedge clk);
    check("midRstX", xAddress, 0);
    check("midRstY", yAddress, 0);
    check("midRstCx", centreX, 0);
    check("midRstTap", tapIndex, 0);
    check("midRstValid", addrValid, 0);
    check("midRstBusy", busy, 0);
    check("midRstDone", imageDone, 0);
    reset       = 1'b1;
    start       = 1'b0;
    nextAddress = 1'b0;
    runScan(4, 3, 0, 0, 0, acc);
    check("afterRstAccepts", acc, 108);

    // Widest image row: right-edge clamp must not wrap.
    runScan(255, 1, 0, 0, 0, acc);
    check("w255Accepts", acc, 255 * 9);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
